nv_ram_rwsthp_fifo_ctrl: RTL and testbench
==========================================

Name: nv_ram_rwsthp_fifo_ctrl

Overview:
- FIFO controller that is the client of a 2-cycle-latency, 2-port bypass RAM (rwsthp-style, 80x17).
- Provides valid/ready push and pop interfaces.
- Drives the RAM write and read ports (wa/we/di, ra/re/ore, byp_sel/dbyp) and consumes its registered dout.
- Sits between a producer and consumer pipe stage wherever an 80-deep flop-free FIFO is needed.

Parameters:
- DEPTH, 80, RAM entries; pointers wrap at DEPTH-1 (not a power of two).
- WIDTH, 17, payload bits.
- AW, 7, address width = ceil(log2(DEPTH)).

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- wr_pvld  in  1  push valid.
- wr_prdy  out  1  push ready.
- wr_pd  in  WIDTH  push payload.
- rd_pvld  out  1  pop valid.
- rd_prdy  in  1  pop ready.
- rd_pd  out  WIDTH  pop payload; equals ram_dout.
- ram_wa  out  AW  RAM write address.
- ram_we  out  1  RAM write enable.
- ram_di  out  WIDTH  RAM write data; equals wr_pd.
- ram_ra  out  AW  RAM read address.
- ram_re  out  1  RAM read-address latch enable.
- ram_ore  out  1  RAM output-register enable.
- ram_byp_sel  out  1  RAM bypass select.
- ram_dbyp  out  WIDTH  RAM bypass data; equals wr_pd.
- ram_dout  in  WIDTH  RAM registered output.
- wr_count  out  AW+1  total occupancy: ram_cnt + s1 + s2.

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-high, ports clk and rst.
- RAM timing contract:
  - re at edge t latches ra.
  - Addressed data is valid combinationally during cycle t+1.
  - ore at edge t+1 loads dout, visible from t+1 onward.
  - RAM holds ra_d/dout while re/ore are low.
- State:
  - wr_ptr, rd_ptr: AW bits, 0..DEPTH-1, wrap DEPTH-1 -> 0.
  - ram_cnt: 0..DEPTH, entries written but not yet read-issued.
  - s1: an address is latched in the RAM; its slot is still owned.
  - s2: the RAM dout holds an unpopped entry.
- Derived terms:
  - pop = rd_pvld & rd_prdy.
  - adv = s1 & (!s2 | pop).
  - push = wr_pvld & wr_prdy.
  - empty_all = (ram_cnt==0) & !s1 & (!s2 | pop).
- Output and enable equations:
  - wr_prdy = !rst & ((ram_cnt + s1) < DEPTH).
  - rd_pvld = s2.
  - byp = push & empty_all.
  - ram_we = push & !byp; ram_wa = wr_ptr.
  - ram_re = (ram_cnt!=0) & (!s1 | adv); ram_ra = rd_ptr.
  - ram_ore = adv | byp.
  - ram_byp_sel = byp; when byp and adv are both true, byp wins (cannot occur, since empty_all implies !s1).
- Updates:
  - ram_we: wr_ptr++ (wrap).
  - ram_re: rd_ptr++ (wrap).
  - ram_cnt += ram_we - ram_re.
  - s1_next = ram_re | (s1 & !adv).
  - s2_next = ram_ore | (s2 & !pop).
- Slot ownership: a slot is freed only when its data moves into the RAM dout (adv), never at re. Max occupancy is DEPTH + 1, with the extra entry held in dout.
- Latency:
  - Push into an empty FIFO (bypass): rd_pvld high the next cycle (1).
  - Push otherwise: commit at +1, re at +1, ore at +2, rd_pvld at +3.
- Throughput: sustained 1 push and 1 pop per cycle at any fill level; no bubbles when rd_prdy stays high.
- Simultaneous push/pop:
  - At full: push is refused (wr_prdy=0) even if pop is high, because wr_prdy has no combinational rd_prdy path.
  - At empty with s2 popping: bypass loads the new entry behind the departing one the same cycle.
- Backpressure: rd_prdy low holds rd_pd stable; s1 holds its address and the RAM is not re-read.
- Reset:
  - All state clears: pointers 0, ram_cnt 0, s1/s2 0.
  - rd_pvld=0, wr_prdy=0 while rst is high and 1 after release; all RAM enables 0; wr_count 0.
  - Reset mid-stream discards contents; RAM array contents are don't-care.

Decomposition:
- Shared package: DEPTH, WIDTH, AW constants, and a wrap-increment function for non-power-of-2 pointers.
- One natural sub-module, nv_fifo_ptr_wrap: pointer register with enable, wrap, and reset. Instance it twice (wr, rd).
- The RAM itself lives outside the block; the bench instantiates it.

Test Plan:
- Reset then single push 0x1ABCD into empty -> byp_sel=1, ore=1 same cycle; rd_pvld=1, rd_pd=0x1ABCD next cycle; we never asserted.
- 80 pushes with rd_prdy=0 -> first goes to dout via bypass, 79 to RAM, then 1 more (81 total); wr_prdy=0 with wr_count=81; pop all with rd_prdy=1 -> values in order, 1/cycle, wr_count reaches 0.
- Continuous push+pop for 200 cycles, incrementing data -> in-order stream, pointers wrap 79->0 twice, no bubble after fill, ram_cnt bounded.
- rd_prdy toggling 1/0 with queue depth 5 -> rd_pd stable while stalled; re only when s1 is free or advancing; no duplicated or dropped entries.
- Full FIFO, push and pop asserted same cycle -> push refused, pop accepted, wr_prdy=1 next cycle.
- Assert rst mid-stream (count 37) -> rd_pvld=0 and wr_count=0 immediately; after release, push 0x00055 returns 0x00055 via bypass.

Source files
------------

// File: rtl/nv_ram_rwsthp_fifo_ctrl_pkg.sv
// Shared constants and helpers for the 80x17 rwsthp RAM FIFO controller.
// Pointers wrap at DEPTH-1 since DEPTH is not a power of two.
package nv_ram_rwsthp_fifo_ctrl_pkg;

  localparam int DEPTH = 80;
  localparam int WIDTH = 17;
  localparam int AW    = 7;

  typedef logic [AW-1:0]    addr_t;
  typedef logic [AW:0]      cnt_t;
  typedef logic [WIDTH-1:0] data_t;

  function automatic addr_t wrap_inc(input addr_t p);
    return (p == addr_t'(DEPTH - 1)) ? '0 : p + addr_t'(1);
  endfunction

endpackage

// File: rtl/nv_fifo_ptr_wrap.sv
// RAM address pointer: increments on enable, wraps DEPTH-1 -> 0.
// Used for both the write and the read side.
module nv_fifo_ptr_wrap
  import nv_ram_rwsthp_fifo_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  output addr_t ptr
);

  addr_t ptr_q;
  addr_t ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = wrap_inc(ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/nv_ram_rwsthp_fifo_ctrl.sv
// Valid/ready FIFO built on an external 2-cycle bypass RAM.
// s1 = address latched in RAM, s2 = RAM dout holds an unpopped entry.
module nv_ram_rwsthp_fifo_ctrl
  import nv_ram_rwsthp_fifo_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  output logic             ram_byp_sel,
  output logic [WIDTH-1:0] ram_dbyp,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [AW:0]      wr_count
);

  cnt_t ram_cnt_q, ram_cnt_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  logic pop, adv, push, empty_all;
  logic byp, we, re, ore, prdy;
  cnt_t occ;

  always_comb begin
    pop       = s2_q & rd_prdy;
    adv       = s1_q & (!s2_q | pop);
    occ       = ram_cnt_q + cnt_t'(s1_q);
    // No rd_prdy term here: a full FIFO refuses push even while popping.
    prdy      = !rst & (occ < cnt_t'(DEPTH));
    push      = wr_pvld & prdy;
    empty_all = (ram_cnt_q == '0) & !s1_q & (!s2_q | pop);
    byp       = push & empty_all;
    we        = push & !byp;
    re        = (ram_cnt_q != '0) & (!s1_q | adv);
    ore       = adv | byp;
    ram_cnt_d = ram_cnt_q + cnt_t'(we) - cnt_t'(re);
    // The s1 slot is released only when its data reaches dout.
    s1_d      = re | (s1_q & !adv);
    s2_d      = ore | (s2_q & !pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_cnt_q <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
    end else begin
      ram_cnt_q <= ram_cnt_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
    end
  end

  nv_fifo_ptr_wrap u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (we),
    .ptr (ram_wa)
  );

  nv_fifo_ptr_wrap u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (re),
    .ptr (ram_ra)
  );

  assign wr_prdy     = prdy;
  assign rd_pvld     = s2_q;
  assign rd_pd       = ram_dout;
  assign ram_we      = we;
  assign ram_di      = wr_pd;
  assign ram_re      = re;
  assign ram_ore     = ore;
  assign ram_byp_sel = byp;
  assign ram_dbyp    = wr_pd;
  assign wr_count    = ram_cnt_q + cnt_t'(s1_q) + cnt_t'(s2_q);

endmodule

// File: tb/tb_nv_ram_rwsthp_fifo_ctrl.sv
// Bench for nv_ram_rwsthp_fifo_ctrl: RAM model plus queue reference.
// Random and directed traffic, every check routed through chk.
module tb_nv_ram_rwsthp_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [16:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [16:0] rd_pd;
  logic [6:0]  ram_wa;
  logic        ram_we;
  logic [16:0] ram_di;
  logic [6:0]  ram_ra;
  logic        ram_re;
  logic        ram_ore;
  logic        ram_byp_sel;
  logic [16:0] ram_dbyp;
  logic [16:0] ram_dout;
  logic [7:0]  wr_count;

  always #5 clk = ~clk;

  nv_ram_rwsthp_fifo_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_pvld     (wr_pvld),
    .wr_prdy     (wr_prdy),
    .wr_pd       (wr_pd),
    .rd_pvld     (rd_pvld),
    .rd_prdy     (rd_prdy),
    .rd_pd       (rd_pd),
    .ram_wa      (ram_wa),
    .ram_we      (ram_we),
    .ram_di      (ram_di),
    .ram_ra      (ram_ra),
    .ram_re      (ram_re),
    .ram_ore     (ram_ore),
    .ram_byp_sel (ram_byp_sel),
    .ram_dbyp    (ram_dbyp),
    .ram_dout    (ram_dout),
    .wr_count    (wr_count)
  );

  // RAM model: 2-cycle read, output register, bypass path.
  logic [16:0] mem [0:79];
  logic [6:0]  ra_q;
  logic [79:0] live;

  always @(posedge clk) begin
    if (rst) begin
      live <= '0;
    end else begin
      if (ram_we) begin
        mem[ram_wa]  <= ram_di;
        live[ram_wa] <= 1'b1;
      end
      if (ram_re) ra_q <= ram_ra;
      if (ram_ore) begin
        ram_dout <= ram_byp_sel ? ram_dbyp : mem[ra_q];
        if (!ram_byp_sel) live[ra_q] <= 1'b0;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [16:0] q [$];
  logic        hold_chk = 1'b0;
  logic [16:0] hold_pd;
  logic        m_prdy, m_pvld, m_byp, m_ore, m_we, m_re;
  logic [16:0] m_pd;
  logic [7:0]  m_cnt;
  logic        pushed, popped;
  int          wraps = 0;

  task automatic cyc(input logic vld, input logic [16:0] pd,
                     input logic rdy);
    @(negedge clk);
    wr_pvld = vld;
    wr_pd   = pd;
    rd_prdy = rdy;
    #1;
    m_prdy = wr_prdy;
    m_pvld = rd_pvld;
    m_byp  = ram_byp_sel;
    m_ore  = ram_ore;
    m_we   = ram_we;
    m_re   = ram_re;
    m_pd   = rd_pd;
    m_cnt  = wr_count;
    chk("count", 32'(m_cnt), 32'(q.size()));
    chk("di", 32'(ram_di), 32'(pd));
    chk("we_byp", 32'(m_we & m_byp), 0);
    if (hold_chk) chk("hold", 32'(m_pd), 32'(hold_pd));
    if (m_pvld) chk("pvld_nonempty", 32'(q.size() != 0), 1);
    if (q.size() <= 79) chk("prdy_room", 32'(m_prdy), 1);
    else if (q.size() >= 81) chk("prdy_full", 32'(m_prdy), 0);
    if (m_we) chk("overwrite", 32'(live[ram_wa]), 0);
    if (m_re) chk("read_live", 32'(live[ram_ra]), 1);
    if (m_we && ram_wa == 7'd79) wraps++;
    pushed = vld && m_prdy;
    popped = m_pvld && rdy;
    if (popped && q.size() != 0) begin
      chk("data", 32'(m_pd), 32'(q[0]));
      void'(q.pop_front());
    end
    if (pushed) q.push_back(pd);
    hold_chk = m_pvld && !rdy;
    hold_pd  = m_pd;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) cyc(0, '0, 1);
    chk("drained", 32'(q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, k, bub;
    logic [16:0] d;
    rst = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pvld", 32'(rd_pvld), 0);
    chk("rst_prdy", 32'(wr_prdy), 0);
    chk("rst_cnt", 32'(wr_count), 0);
    chk("rst_en", 32'({ram_we, ram_re, ram_ore, ram_byp_sel}), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_prdy", 32'(wr_prdy), 1);

    // single push into empty takes the bypass path
    cyc(1, 17'h1ABCD, 0);
    chk("byp_sel", 32'(m_byp), 1);
    chk("byp_ore", 32'(m_ore), 1);
    chk("byp_we", 32'(m_we), 0);
    cyc(0, '0, 0);
    chk("byp_pvld", 32'(m_pvld), 1);
    chk("byp_pd", 32'(m_pd), 32'h1ABCD);
    chk("byp_we2", 32'(m_we), 0);
    cyc(0, '0, 1);

    // fill to DEPTH+1 with consumer stalled
    n = 0; d = 17'h100;
    for (int i = 0; i < 120; i++) begin
      cyc(1, d, 0);
      if (pushed) begin n++; d++; end
      if (!m_prdy) break;
    end
    chk("fill_n", 32'(n), 81);
    chk("fill_cnt", 32'(m_cnt), 81);
    cyc(1, d, 1);
    chk("full_push_refused", 32'(pushed), 0);
    chk("full_pop_taken", 32'(popped), 1);
    cyc(0, '0, 1);
    chk("full_prdy_back", 32'(m_prdy), 1);
    k = 0;
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      cyc(0, '0, 1);
      k++;
    end
    chk("drain_cycles", 32'(k), 79);
    cyc(0, '0, 0);
    chk("drain_cnt", 32'(m_cnt), 0);

    // prefill then stream 200 push+pop cycles
    d = 17'h2000;
    for (int i = 0; i < 5; i++) begin cyc(1, d, 0); d++; end
    bub = 0; n = 0; wraps = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1, d, 1);
      if (pushed) begin n++; d++; end
      if (!m_pvld) bub++;
    end
    chk("stream_push", 32'(n), 200);
    chk("stream_bubbles", 32'(bub), 0);
    chk("stream_wraps", 32'(wraps >= 2), 1);
    chk("stream_level", 32'(q.size()), 5);
    drain(50);

    // depth-5 queue with toggling consumer
    for (int i = 0; i < 200; i++)
      cyc(q.size() < 5, 17'($urandom), 1'(i % 2));
    drain(50);

    // random traffic, first filling then mostly draining
    for (int i = 0; i < 600; i++)
      cyc($urandom % 4 != 0, 17'($urandom),
          (i < 300) ? ($urandom % 3 == 0) : ($urandom % 4 != 0));
    drain(200);

    // reset mid-stream at occupancy 37
    for (int i = 0; i < 80 && q.size() < 37; i++)
      cyc(1, 17'($urandom), 0);
    chk("pre_rst_level", 32'(q.size()), 37);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_pvld", 32'(rd_pvld), 0);
    chk("mid_rst_cnt", 32'(wr_count), 0);
    chk("mid_rst_prdy", 32'(wr_prdy), 0);
    chk("mid_rst_en", 32'({ram_we, ram_re, ram_ore}), 0);
    q.delete();
    hold_chk = 1'b0;
    wr_pvld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 17'h00055, 0);
    chk("post_rst_byp", 32'(m_byp), 1);
    cyc(0, '0, 0);
    chk("post_rst_pvld", 32'(m_pvld), 1);
    chk("post_rst_pd", 32'(m_pd), 32'h55);
    cyc(0, '0, 1);
    cyc(0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
